// File: rtl/hazard_forw_ctrl.sv
// EX-operand forwarding select and load-use stall generator.
// Keeps a two-slot EX/MEM destination scoreboard beside the ID/EX register.
module hazard_forw_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isForw_ON,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [6:0]        id_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        forwA,
  output logic [1:0]        forwB,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_IMM  = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_I_JALR = 7'b1100111;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } sb_t;

  typedef enum logic {
    S_RUN,
    S_STALL
  } state_t;

  sb_t        r_ex;
  sb_t        r_mem;
  sb_t        w_id;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_forwA;
  logic [1:0] r_forwB;
  logic [1:0] w_forwA_nxt;
  logic [1:0] w_forwB_nxt;
  logic       w_use1;
  logic       w_use2;
  logic       w_ex1;
  logic       w_ex2;
  logic       w_mem1;
  logic       w_mem2;
  logic       w_lu;
  logic       w_nf;
  logic       w_stall;
  logic       w_bub;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  function automatic logic f_match(
    input sb_t               s,
    input logic [REG_AW-1:0] rs
  );
    return s.valid & s.reg_write &
           (s.rd == rs) & (rs != '0);
  endfunction

  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (id_op)
      OP_R, OP_S, OP_B: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OP_I_IMM, OP_I_LOAD, OP_I_JALR:
        w_use1 = 1'b1;
      default: ;
    endcase
  end

  assign w_ex1  = w_use1 & f_match(r_ex, id_rs1);
  assign w_ex2  = w_use2 & f_match(r_ex, id_rs2);
  assign w_mem1 = w_use1 & f_match(r_mem, id_rs1);
  assign w_mem2 = w_use2 & f_match(r_mem, id_rs2);

  assign w_lu = id_valid & r_ex.mem_read & (w_ex1 | w_ex2);
  // Without forwarding, every in-flight producer must drain first
  assign w_nf = id_valid & ~isForw_ON &
                (w_ex1 | w_ex2 | w_mem1 | w_mem2);

  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          w_stall = w_lu | w_nf;
          if (w_lu & isForw_ON)
            w_state_nxt = S_STALL;
        end
        S_STALL: w_state_nxt = S_RUN;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  assign w_bub = w_stall | flush | ~id_valid;

  always_comb begin
    w_id.valid     = ~w_bub;
    w_id.rd        = id_rd;
    w_id.reg_write = id_reg_write;
    w_id.mem_read  = id_mem_read;
  end

  always_comb begin
    w_forwA_nxt = SEL_RF;
    w_forwB_nxt = SEL_RF;
    if (!w_bub && isForw_ON) begin
      if (w_ex1)       w_forwA_nxt = SEL_EX;
      else if (w_mem1) w_forwA_nxt = SEL_MEM;
      if (w_ex2)       w_forwB_nxt = SEL_EX;
      else if (w_mem2) w_forwB_nxt = SEL_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_state     <= S_RUN;
      r_forwA     <= SEL_RF;
      r_forwB     <= SEL_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_mem       <= r_ex;
      r_ex        <= w_id;
      r_state     <= w_state_nxt;
      r_forwA     <= w_forwA_nxt;
      r_forwB     <= w_forwB_nxt;
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(flush);
    end
  end

  assign forwA     = r_forwA;
  assign forwB     = r_forwB;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_forw_ctrl.sv
// Directed-vector bench for hazard_forw_ctrl.
// Each task drives one scenario and checks inline.
module tb_hazard_forw_ctrl;

  localparam logic [6:0] R      = 7'b0110011;
  localparam logic [6:0] I_IMM  = 7'b0010011;
  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] U_LUI  = 7'b0110111;
  localparam logic [6:0] J_JAL  = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        isForw_ON = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [6:0]  id_op = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic [4:0]  id_rd = '0;
  logic        id_reg_write = 1'b0;
  logic        id_mem_read = 1'b0;
  logic [1:0]  forwA;
  logic [1:0]  forwB;
  logic        stall;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_forw_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .isForw_ON(isForw_ON),
    .flush(flush), .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forwA(forwA), .forwB(forwB), .stall(stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic set_id(input logic v, input logic [6:0] op,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw,
                        input logic mr);
    id_valid = v; id_op = op; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic idle();
    set_id(1'b0, I_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0;
    isForw_ON = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({forwA, forwB, stall} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs: got fA=%b fB=%b st=%b, need 0",
               forwA, forwB, stall);
    end
    n_chk++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d, need 0/0",
               stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_ex_forward();
    do_reset();
    set_id(1'b1, R, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, R, 5'd1, 5'd5, 5'd4, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL ex_fwd_stall: got %b, need 0", stall);
    end
    tick();
    n_chk++;
    if (forwA !== 2'b01 || forwB !== 2'b00) begin
      n_err++;
      $display("FAIL ex_fwd_sel: got %b/%b, need 01/00", forwA, forwB);
    end
    idle();
  endtask

  task automatic test_mem_forward();
    do_reset();
    set_id(1'b1, R, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    set_id(1'b1, R, 5'd7, 5'd1, 5'd6, 1'b1, 1'b0);
    tick();
    n_chk++;
    if (forwA !== 2'b00 || forwB !== 2'b10) begin
      n_err++;
      $display("FAIL mem_fwd_sel: got %b/%b, need 00/10", forwA, forwB);
    end
    set_id(1'b1, R, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, I_IMM, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, R, 5'd1, 5'd1, 5'd8, 1'b1, 1'b0);
    tick();
    n_chk++;
    if (forwA !== 2'b01 || forwB !== 2'b01) begin
      n_err++;
      $display("FAIL priority_sel: got %b/%b, need 01/01", forwA, forwB);
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, I_LOAD, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, R, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL lu_stall_on: got %b, need 1", stall);
    end
    tick();
    n_chk++;
    if (stall !== 1'b0 || forwA !== 2'b00) begin
      n_err++;
      $display("FAIL lu_bubble: got st=%b fA=%b, need 0/00",
               stall, forwA);
    end
    tick();
    n_chk++;
    if (forwA !== 2'b10 || forwB !== 2'b10 || stall_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL lu_sel: got %b/%b cnt=%0d, need 10/10 cnt=1",
               forwA, forwB, stall_cnt);
    end
    idle();
  endtask

  task automatic test_x0_unused();
    do_reset();
    set_id(1'b1, R, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, R, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL x0_stall: got %b, need 0", stall);
    end
    tick();
    n_chk++;
    if (forwA !== 2'b00 || forwB !== 2'b00) begin
      n_err++;
      $display("FAIL x0_sel: got %b/%b, need 00/00", forwA, forwB);
    end
    set_id(1'b1, U_LUI, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, J_JAL, 5'd1, 5'd1, 5'd9, 1'b1, 1'b0);
    tick();
    n_chk++;
    if (forwA !== 2'b00 || forwB !== 2'b00) begin
      n_err++;
      $display("FAIL jal_sel: got %b/%b, need 00/00", forwA, forwB);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, I_LOAD, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, R, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: got %b, need 0", stall);
    end
    tick();
    flush = 1'b0;
    set_id(1'b1, R, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (forwA !== 2'b00 || flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL flush_cnt: got fA=%b f=%0d s=%0d, need 00/1/0",
               forwA, flush_cnt, stall_cnt);
    end
    tick();
    n_chk++;
    if (forwA !== 2'b00) begin
      n_err++;
      $display("FAIL flush_ex_bubble: got %b, need 00", forwA);
    end
    idle();
  endtask

  task automatic test_no_forward();
    do_reset();
    isForw_ON = 1'b0;
    set_id(1'b1, R, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, R, 5'd1, 5'd1, 5'd4, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL nf_stall1: got %b, need 1", stall);
    end
    tick();
    n_chk++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL nf_stall2: got %b, need 1", stall);
    end
    tick();
    n_chk++;
    if (stall !== 1'b0 || stall_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL nf_release: got st=%b cnt=%0d, need 0/2",
               stall, stall_cnt);
    end
    tick();
    n_chk++;
    if (forwA !== 2'b00 || forwB !== 2'b00) begin
      n_err++;
      $display("FAIL nf_sel: got %b/%b, need 00/00", forwA, forwB);
    end
    idle();
    isForw_ON = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, I_LOAD, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, R, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    tick();
    set_id(1'b1, I_LOAD, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, R, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (stall !== 1'b1 || stall_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL rst_pre: got st=%b cnt=%0d, need 1/1",
               stall, stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b0 || forwA !== 2'b00 || forwB !== 2'b00 ||
        stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid: got st=%b %b/%b cnt=%0d/%0d, need 0",
               stall, forwA, forwB, stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: got %b, need 0", stall);
    end
    tick();
    n_chk++;
    if (forwA !== 2'b00 || stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rst_after: got fA=%b cnt=%0d, need 00/0",
               forwA, stall_cnt);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_no_forward();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
